chan_mem_arb: RTL and testbench
===============================

CHAN_MEM_ARB -- requirements
Module: chan_mem_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, channel memory word-address width (128 words).
REQ-002 SHALL have parameter DATA_W, default 32, channel memory word width.
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-004 a_rd_stb  input  1  channel-controller read request.
REQ-005 a_rd_addr  input  ADDR_W  channel-controller read address.
REQ-006 a_rd_data  output  DATA_W  read data, registered.
REQ-007 a_wr_stb  input  1  channel-controller write strobe.
REQ-008 a_wr_addr  input  ADDR_W  channel-controller write address.
REQ-009 a_wr_data  input  DATA_W  channel-controller write data.
REQ-010 h_req  input  1  host request, held until h_ack.
REQ-011 h_we  input  1  host operation: 1 = write, 0 = read.
REQ-012 h_addr  input  ADDR_W  host address.
REQ-013 h_wdata  input  DATA_W  host write data.
REQ-014 h_be  input  DATA_W/8  host byte enables.
REQ-015 h_rdata  output  DATA_W  host read data, valid with h_ack.
REQ-016 h_ack  output  1  one-cycle transaction-complete pulse.
REQ-017 stall_cnt  output  16  saturating count of host-denied cycles.

Function
REQ-018 Memory SHALL be 1R1W, 2^ADDR_W words; the read and write ports SHALL be arbitrated independently.
REQ-019 Port A SHALL have absolute priority on each port: a_rd_stb at cycle N -> a_rd_data valid at N+1, never delayed.
REQ-020 a_wr_stb SHALL write all bytes in the same cycle; a_rd_data SHALL hold its value when a_rd_stb=0.
REQ-021 Host FSM states SHALL be IDLE, ISSUE, RDWAIT, ACK.
REQ-022 IDLE->ISSUE on h_req=1; latch h_we, h_addr, h_wdata and h_be at that edge.
REQ-023 ISSUE: grant when the needed port is idle that cycle (no a_wr_stb for a write, no a_rd_stb for a read); write grant->ACK, read grant->RDWAIT; otherwise stay in ISSUE and increment stall_cnt.
REQ-024 RDWAIT->ACK unconditionally; h_rdata SHALL be captured from the RAM output.
REQ-025 ACK SHALL assert h_ack for exactly one cycle, then go to IDLE; h_req still high in IDLE SHALL start a new transaction.
REQ-026 Host write SHALL update only bytes with h_be=1; h_be=0 SHALL complete with ack and leave memory unchanged.
REQ-027 Read and write of the same address in the same cycle SHALL return the old data, unless CHAN_MEM_ARB_BYPASS_EN is defined (REQ-034).
REQ-028 A pending host write to an address written by port A SHALL be performed after port A's write; the host value wins.
REQ-029 stall_cnt SHALL saturate at 16'hFFFF.
REQ-030 Latency without contention: write req->h_ack = 2 cycles; read req->h_ack = 3 cycles.

Reset
REQ-031 rst SHALL set FSM=IDLE, h_ack=0, h_rdata=0, a_rd_data=0 and stall_cnt=0; memory contents SHALL be unchanged.
REQ-032 rst mid-transaction SHALL abandon the transaction with no h_ack and no write if the write was not yet granted.
REQ-033 Strobes asserted during rst SHALL be ignored.

Configuration
REQ-034 CHAN_MEM_ARB_BYPASS_EN defined: a same-cycle same-address read SHALL return the newly written data, merged per byte enable. Undefined: the read SHALL return the old data.

Structure
REQ-035 Package chan_arb_pkg SHALL hold ADDR_W/DATA_W defaults and the host FSM state enum.
REQ-036 Sub-module chan_mem SHALL be the 1R1W byte-enable RAM with registered read, including the optional bypass mux.

Verification
REQ-037 Idle port A; host write addr 5, data 32'hDEADBEEF, be 4'hF -> h_ack 2 cycles after req; host read addr 5 -> h_rdata 32'hDEADBEEF, ack after 3 cycles.
REQ-038 a_rd_stb held high for 10 cycles while host read pending -> a_rd_data each cycle N+1; host ack at cycle 13; stall_cnt=10.
REQ-039 Mem[3]=32'h11223344; host write be 4'b0101, data 32'hAABBCCDD -> reads 32'h11BB33DD.
REQ-040 Same cycle a_wr_stb addr 9 = 32'h1 and a_rd_stb addr 9 (old value 0) -> a_rd_data 0 without the macro, 32'h1 with it.
REQ-041 rst asserted in RDWAIT -> no h_ack, FSM IDLE, stall_cnt 0, previously written memory intact.
REQ-042 Port A write addr 7 = 32'h5 while host write addr 7 = 32'h9 is pending -> final mem[7]=32'h9.

Source files
------------

// File: rtl/chan_arb_pkg.sv
// Shared defaults, host FSM state encoding and helpers for the channel memory arbiter.
package chan_arb_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    HS_IDLE   = 2'd0,
    HS_ISSUE  = 2'd1,
    HS_RDWAIT = 2'd2,
    HS_ACK    = 2'd3
  } host_state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == 16'hFFFF) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/chan_mem.sv
// 1R1W byte-enable RAM with registered read; the read register is split per requester.
// Optional same-address write-to-read bypass when CHAN_MEM_ARB_BYPASS_EN is defined.
module chan_mem
  import chan_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic                rd_sel,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data_a,
  output logic [DATA_W-1:0]   rd_data_h
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_word_s;
  logic              byp_s;

`ifdef CHAN_MEM_ARB_BYPASS_EN
  assign byp_s = wr_en && (wr_addr == rd_addr);
`else
  assign byp_s = 1'b0;
`endif

  // Write port: per-byte update, contents survive reset
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) begin
          mem_r[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read word, optionally merged with the in-flight write bytes
  always_comb begin
    rd_word_s = mem_r[rd_addr];
    for (int b = 0; b < BE_W; b++) begin
      rd_word_s[b*8 +: 8] = (byp_s && wr_be[b]) ? wr_data[b*8 +: 8] : mem_r[rd_addr][b*8 +: 8];
    end
  end

  // Read registers: each holds until its own requester reads again
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_a <= {DATA_W{1'b0}};
      rd_data_h <= {DATA_W{1'b0}};
    end else begin
      if (rd_en && !rd_sel) begin
        rd_data_a <= rd_word_s;
      end
      if (rd_en && rd_sel) begin
        rd_data_h <= rd_word_s;
      end
    end
  end

endmodule

// File: rtl/chan_mem_arb.sv
// Channel memory arbiter: port A has absolute priority on each RAM port, host waits.
// Build option: CHAN_MEM_ARB_BYPASS_EN (same-cycle same-address read returns new data).
module chan_mem_arb
  import chan_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a_rd_stb,
  input  logic [ADDR_W-1:0]   a_rd_addr,
  output logic [DATA_W-1:0]   a_rd_data,
  input  logic                a_wr_stb,
  input  logic [ADDR_W-1:0]   a_wr_addr,
  input  logic [DATA_W-1:0]   a_wr_data,
  input  logic                h_req,
  input  logic                h_we,
  input  logic [ADDR_W-1:0]   h_addr,
  input  logic [DATA_W-1:0]   h_wdata,
  input  logic [DATA_W/8-1:0] h_be,
  output logic [DATA_W-1:0]   h_rdata,
  output logic                h_ack,
  output logic [15:0]         stall_cnt
);

  localparam int BE_W = DATA_W / 8;

  host_state_e         state_r, state_s;
  logic                h_we_r;
  logic [ADDR_W-1:0]   h_addr_r;
  logic [DATA_W-1:0]   h_wdata_r;
  logic [BE_W-1:0]     h_be_r;
  logic [DATA_W-1:0]   h_rdata_r;
  logic                h_ack_r;
  logic [15:0]         stall_r;

  logic                host_wr_gnt_s, host_rd_gnt_s, stall_s;
  logic                mem_wr_en_s, mem_rd_en_s, mem_rd_sel_s;
  logic [ADDR_W-1:0]   mem_wr_addr_s, mem_rd_addr_s;
  logic [DATA_W-1:0]   mem_wr_data_s, mem_rd_h_s;
  logic [BE_W-1:0]     mem_wr_be_s;

  // Host FSM next state and grant decisions
  always_comb begin
    state_s       = state_r;
    host_wr_gnt_s = 1'b0;
    host_rd_gnt_s = 1'b0;
    stall_s       = 1'b0;
    case (state_r)
      HS_IDLE: begin
        if (h_req) begin
          state_s = HS_ISSUE;
        end else begin
          state_s = HS_IDLE;
        end
      end
      HS_ISSUE: begin
        if (h_we_r ? !a_wr_stb : !a_rd_stb) begin
          host_wr_gnt_s = h_we_r;
          host_rd_gnt_s = !h_we_r;
          state_s       = h_we_r ? HS_ACK : HS_RDWAIT;
        end else begin
          stall_s = 1'b1;
          state_s = HS_ISSUE;
        end
      end
      HS_RDWAIT: state_s = HS_ACK;
      HS_ACK:    state_s = HS_IDLE;
      default:   state_s = HS_IDLE;
    endcase
  end

  // RAM port steering: port A owns a port whenever it strobes it
  always_comb begin
    mem_wr_en_s = a_wr_stb | host_wr_gnt_s;
    mem_rd_en_s = a_rd_stb | host_rd_gnt_s;
    mem_rd_sel_s = !a_rd_stb;
    if (a_wr_stb) begin
      mem_wr_addr_s = a_wr_addr;
      mem_wr_data_s = a_wr_data;
      mem_wr_be_s   = {BE_W{1'b1}};
    end else begin
      mem_wr_addr_s = h_addr_r;
      mem_wr_data_s = h_wdata_r;
      mem_wr_be_s   = h_be_r;
    end
    if (a_rd_stb) begin
      mem_rd_addr_s = a_rd_addr;
    end else begin
      mem_rd_addr_s = h_addr_r;
    end
  end

  // FSM state, latched host request, host outputs and stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= HS_IDLE;
      h_we_r    <= 1'b0;
      h_addr_r  <= {ADDR_W{1'b0}};
      h_wdata_r <= {DATA_W{1'b0}};
      h_be_r    <= {BE_W{1'b0}};
      h_rdata_r <= {DATA_W{1'b0}};
      h_ack_r   <= 1'b0;
      stall_r   <= 16'd0;
    end else begin
      state_r <= state_s;
      h_ack_r <= (state_s == HS_ACK);
      if (state_r == HS_IDLE && h_req) begin
        h_we_r    <= h_we;
        h_addr_r  <= h_addr;
        h_wdata_r <= h_wdata;
        h_be_r    <= h_be;
      end
      if (state_r == HS_RDWAIT) begin
        h_rdata_r <= mem_rd_h_s;
      end
      if (stall_s) begin
        stall_r <= sat_inc16(stall_r);
      end
    end
  end

  chan_mem #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (mem_wr_en_s),
    .wr_addr   (mem_wr_addr_s),
    .wr_data   (mem_wr_data_s),
    .wr_be     (mem_wr_be_s),
    .rd_en     (mem_rd_en_s),
    .rd_sel    (mem_rd_sel_s),
    .rd_addr   (mem_rd_addr_s),
    .rd_data_a (a_rd_data),
    .rd_data_h (mem_rd_h_s)
  );

  assign h_rdata   = h_rdata_r;
  assign h_ack     = h_ack_r;
  assign stall_cnt = stall_r;

endmodule

// File: tb/tb_chan_mem_arb.sv
// Directed, table-driven bench for chan_mem_arb plus hand-written contention/reset sequences.
module tb_chan_mem_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_rd_stb;
  logic [6:0]  a_rd_addr;
  logic [31:0] a_rd_data;
  logic        a_wr_stb;
  logic [6:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        h_req;
  logic        h_we;
  logic [6:0]  h_addr;
  logic [31:0] h_wdata;
  logic [3:0]  h_be;
  logic [31:0] h_rdata;
  logic        h_ack;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          we;
    logic [6:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  chan_mem_arb dut (
    .clk       (clk),
    .rst       (rst),
    .a_rd_stb  (a_rd_stb),
    .a_rd_addr (a_rd_addr),
    .a_rd_data (a_rd_data),
    .a_wr_stb  (a_wr_stb),
    .a_wr_addr (a_wr_addr),
    .a_wr_data (a_wr_data),
    .h_req     (h_req),
    .h_we      (h_we),
    .h_addr    (h_addr),
    .h_wdata   (h_wdata),
    .h_be      (h_be),
    .h_rdata   (h_rdata),
    .h_ack     (h_ack),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one host transaction, return read data and req->ack latency in cycles
  task automatic host_op(input bit we, input logic [6:0] addr, input logic [31:0] data,
                         input logic [3:0] be, output logic [31:0] rdata, output int lat);
    h_req = 1'b1; h_we = we; h_addr = addr; h_wdata = data; h_be = be;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!h_ack && lat < 50);
    rdata = h_rdata;
    h_req = 1'b0;
    tick();
  endtask

  task automatic port_a_read(input logic [6:0] addr, output logic [31:0] d);
    a_rd_stb = 1'b1; a_rd_addr = addr;
    tick();
    a_rd_stb = 1'b0;
    d = a_rd_data;
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] exp_byp;
    int          lat;
    int          acks;

    vecs[0]  = '{1'b1, 7'd5,   32'hDEADBEEF, 4'hF, 32'h0,        2};
    vecs[1]  = '{1'b0, 7'd5,   32'h0,        4'h0, 32'hDEADBEEF, 3};
    vecs[2]  = '{1'b1, 7'd3,   32'h11223344, 4'hF, 32'h0,        2};
    vecs[3]  = '{1'b1, 7'd3,   32'hAABBCCDD, 4'h5, 32'h0,        2};
    vecs[4]  = '{1'b0, 7'd3,   32'h0,        4'h0, 32'h11BB33DD, 3};
    vecs[5]  = '{1'b1, 7'd10,  32'h12345678, 4'hF, 32'h0,        2};
    vecs[6]  = '{1'b1, 7'd10,  32'hFFFFFFFF, 4'h0, 32'h0,        2};
    vecs[7]  = '{1'b0, 7'd10,  32'h0,        4'h0, 32'h12345678, 3};
    vecs[8]  = '{1'b1, 7'd127, 32'hA5A5A5A5, 4'hF, 32'h0,        2};
    vecs[9]  = '{1'b0, 7'd127, 32'h0,        4'h0, 32'hA5A5A5A5, 3};
    vecs[10] = '{1'b1, 7'd0,   32'h0F0F0F0F, 4'hF, 32'h0,        2};
    vecs[11] = '{1'b1, 7'd0,   32'hFFFFFFFF, 4'hA, 32'h0,        2};
    vecs[12] = '{1'b0, 7'd0,   32'h0,        4'h0, 32'hFF0FFF0F, 3};
    vecs[13] = '{1'b1, 7'd9,   32'h00000000, 4'hF, 32'h0,        2};
    vecs[14] = '{1'b0, 7'd9,   32'h0,        4'h0, 32'h00000000, 3};

    rst = 1'b1;
    a_rd_stb = 1'b0; a_rd_addr = 7'd0; a_wr_stb = 1'b0; a_wr_addr = 7'd0; a_wr_data = 32'd0;
    h_req = 1'b0; h_we = 1'b0; h_addr = 7'd0; h_wdata = 32'd0; h_be = 4'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("reset_h_ack", {31'd0, h_ack}, 32'd0);
    check("reset_h_rdata", h_rdata, 32'd0);
    check("reset_a_rd_data", a_rd_data, 32'd0);
    check("reset_stall", {16'd0, stall_cnt}, 32'd0);

    for (int i = 0; i < 15; i++) begin
      host_op(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].be, rd, lat);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      if (!vecs[i].we) begin
        check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
      end
    end

    // Port A read, then hold while a host read uses the RAM read port
    port_a_read(7'd5, rd);
    check("a_read_5", rd, 32'hDEADBEEF);
    a_rd_addr = 7'd3;
    host_op(1'b0, 7'd3, 32'd0, 4'd0, rd, lat);
    check("a_rd_hold", a_rd_data, 32'hDEADBEEF);
    check("a_rd_hold_hostdata", rd, 32'h11BB33DD);

    // Same-cycle write/read of addr 9 (old value 0)
`ifdef CHAN_MEM_ARB_BYPASS_EN
    exp_byp = 32'h1;
`else
    exp_byp = 32'h0;
`endif
    a_wr_stb = 1'b1; a_wr_addr = 7'd9; a_wr_data = 32'h1;
    a_rd_stb = 1'b1; a_rd_addr = 7'd9;
    tick();
    a_wr_stb = 1'b0; a_rd_stb = 1'b0;
    check("same_cycle_rw", a_rd_data, exp_byp);
    port_a_read(7'd9, rd);
    check("after_a_write", rd, 32'h1);

    // Host read stalled by 10 consecutive port-A reads
    h_req = 1'b1; h_we = 1'b0; h_addr = 7'd5;
    tick();
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      a_rd_stb = 1'b1;
      a_rd_addr = (i % 2 == 0) ? 7'd3 : 7'd127;
      tick();
      check($sformatf("stall_a_rd%0d", i), a_rd_data, (i % 2 == 0) ? 32'h11BB33DD : 32'hA5A5A5A5);
      if (h_ack) acks++;
    end
    a_rd_stb = 1'b0;
    tick();
    if (h_ack) acks++;
    check("stall_no_early_ack", acks, 0);
    tick();
    check("stall_ack_cycle13", {31'd0, h_ack}, 32'd1);
    check("stall_rdata", h_rdata, 32'hDEADBEEF);
    check("stall_cnt_10", {16'd0, stall_cnt}, 32'd10);
    h_req = 1'b0;
    tick();

    // Port A write to addr 7 while host write to addr 7 is pending
    h_req = 1'b1; h_we = 1'b1; h_addr = 7'd7; h_wdata = 32'h9; h_be = 4'hF;
    tick();
    a_wr_stb = 1'b1; a_wr_addr = 7'd7; a_wr_data = 32'h5;
    tick();
    a_wr_stb = 1'b0;
    tick();
    check("wr_conflict_ack", {31'd0, h_ack}, 32'd1);
    check("wr_conflict_stall", {16'd0, stall_cnt}, 32'd11);
    h_req = 1'b0;
    tick();
    port_a_read(7'd7, rd);
    check("wr_conflict_host_wins", rd, 32'h9);

    // Reset while in RDWAIT
    h_req = 1'b1; h_we = 1'b0; h_addr = 7'd3;
    tick();
    tick();
    rst = 1'b1; h_req = 1'b0;
    tick();
    rst = 1'b0;
    acks = 0;
    check("rst_rdwait_stall", {16'd0, stall_cnt}, 32'd0);
    check("rst_rdwait_rdata", h_rdata, 32'd0);
    check("rst_rdwait_a_rd", a_rd_data, 32'd0);
    repeat (4) begin
      tick();
      if (h_ack) acks++;
    end
    check("rst_rdwait_no_ack", acks, 0);
    port_a_read(7'd3, rd);
    check("rst_mem_intact", rd, 32'h11BB33DD);

    // Reset at the grant edge of a host write, with port strobes during reset
    h_req = 1'b1; h_we = 1'b1; h_addr = 7'd5; h_wdata = 32'h0; h_be = 4'hF;
    tick();
    rst = 1'b1;
    a_wr_stb = 1'b1; a_wr_addr = 7'd5; a_wr_data = 32'h0;
    a_rd_stb = 1'b1; a_rd_addr = 7'd5;
    tick();
    rst = 1'b0; h_req = 1'b0; a_wr_stb = 1'b0; a_rd_stb = 1'b0;
    check("rst_strobe_a_rd", a_rd_data, 32'd0);
    tick();
    check("rst_wr_no_ack", {31'd0, h_ack}, 32'd0);
    port_a_read(7'd5, rd);
    check("rst_wr_abandoned", rd, 32'hDEADBEEF);

    // Stall counter saturation
    h_req = 1'b1; h_we = 1'b0; h_addr = 7'd0;
    a_rd_stb = 1'b1; a_rd_addr = 7'd0;
    acks = 0;
    for (int i = 0; i < 65540; i++) begin
      tick();
      if (h_ack) acks++;
    end
    check("sat_no_ack", acks, 0);
    check("sat_stall", {16'd0, stall_cnt}, 32'h0000FFFF);
    a_rd_stb = 1'b0;
    host_op(1'b0, 7'd0, 32'd0, 4'd0, rd, lat);
    check("sat_release_rdata", rd, 32'hFF0FFF0F);
    check("sat_hold", {16'd0, stall_cnt}, 32'h0000FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
